// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// sqrt_pkg : shared types and sizing helpers for the sqrt controller
// Rev 1.0
// ============================================================================
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int C_DEFAULT_LEVELS = 6;

    // Each level resolves one result bit; a SIZE-bit operand has SIZE/2 result bits.
    function automatic int calc_max_iter(input int size, input int levels);
        return (size + 2 * levels - 1) / (2 * levels);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_iter_counter.sv
`default_nettype none
// ============================================================================
// sqrt_iter_counter : saturating iteration counter with clear, enable and
//                     terminal-count flag (asserted on the last permitted pass)
// Rev 1.0
// ============================================================================
module sqrt_iter_counter #(
    parameter int MAX_COUNT = 3,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != WIDTH'(MAX_COUNT))) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    assign tc_o = (cnt_q == WIDTH'(MAX_COUNT - 1));

endmodule
`default_nettype wire

// File: rtl/sqrt_controller.sv
`default_nettype none
// ============================================================================
// sqrt_controller : Moore control FSM for the multi-level integer sqrt
//                   datapath, with start/ready and valid/ack handshakes
// Rev 1.0
// ============================================================================
module sqrt_controller
    import sqrt_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int LEVELS   = C_DEFAULT_LEVELS,
    parameter int MAX_ITER = calc_max_iter(SIZE, LEVELS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [SIZE-1:0] in_num_i,
    output logic            ready_o,
    output logic            result_valid_o,
    input  logic            result_ack_i,
    output logic            error_o,
    output logic [SIZE-1:0] dp_num_o,
    output logic            ld_o,
    output logic            mux_select_o,
    output logic            ld_out_o,
    input  logic            finished_i
);

    state_t          state_q, state_d;
    logic [SIZE-1:0] op_q, op_d;
    logic            error_q, error_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_tc;

    sqrt_iter_counter #(
        .MAX_COUNT (MAX_ITER)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        error_d = error_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d    = in_num_i;
                    error_d = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = ITER;
            ITER: begin
                cnt_en = 1'b1;
                // A finishing pass wins over the budget check on the last pass.
                if (finished_i) begin
                    state_d = OUT;
                end else if (cnt_tc) begin
                    error_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT:  state_d = DONE;
            DONE: begin
                if (result_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o        = (state_q == IDLE);
    assign result_valid_o = (state_q == DONE);
    assign error_o        = (state_q == DONE) && error_q;
    assign ld_o           = (state_q == LOAD) || (state_q == ITER);
    assign mux_select_o   = (state_q == LOAD);
    assign ld_out_o       = (state_q == OUT);
    assign dp_num_o       = op_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_controller.sv
`default_nettype none
// ============================================================================
// tb_sqrt_controller : self-checking bench with a behavioural 6-level
//                      datapath and an arithmetic isqrt/latency reference
// Rev 1.0
// ============================================================================
module tb_sqrt_controller;

    localparam int C_SIZE     = 32;
    localparam int C_LEVELS   = 6;
    localparam int C_MAX_ITER = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_num = '0;
    logic        ready, result_valid, error, ld, mux_select, ld_out, finished;
    logic        result_ack = 1'b0;
    logic [31:0] dp_num;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrt_controller #(.SIZE(C_SIZE), .LEVELS(C_LEVELS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .in_num_i       (in_num),
        .ready_o        (ready),
        .result_valid_o (result_valid),
        .result_ack_i   (result_ack),
        .error_o        (error),
        .dp_num_o       (dp_num),
        .ld_o           (ld),
        .mux_select_o   (mux_select),
        .ld_out_o       (ld_out),
        .finished_i     (finished)
    );

    // Behavioural datapath: digit-by-digit sqrt, C_LEVELS levels per pass.
    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] root;
        logic [31:0] pw;
    } dp_t;

    dp_t         dp_cur = '0;
    dp_t         dp_nxt;
    logic [31:0] res = '0;
    logic        force_unf = 1'b0;

    function automatic dp_t dp_levels(input dp_t s);
        dp_t t = s;
        for (int i = 0; i < C_LEVELS; i++) begin
            if (t.pw != 0) begin
                if ({1'b0, t.rem} >= ({1'b0, t.root} + {1'b0, t.pw})) begin
                    t.rem  = t.rem - (t.root + t.pw);
                    t.root = (t.root >> 1) + t.pw;
                end else begin
                    t.root = t.root >> 1;
                end
                t.pw = t.pw >> 2;
            end
        end
        return t;
    endfunction

    function automatic logic [31:0] first_pow(input logic [31:0] x);
        logic [31:0] p = 32'h4000_0000;
        while (p > x) p = p >> 2;
        return p;
    endfunction

    always_comb dp_nxt = dp_levels(dp_cur);
    assign finished = force_unf ? 1'b0 : (dp_nxt.pw == 32'd0);

    always @(posedge clk) begin
        if (ld) dp_cur <= mux_select ? {dp_num, 32'd0, first_pow(dp_num)} : dp_nxt;
        if (ld_out) res <= dp_nxt.root;
    end

    // Reference model: plain arithmetic from the operation rules.
    function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        longint xv = longint'({32'd0, x});
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= xv) lo = mid;
            else hi = mid;
        end
        return 32'(lo);
    endfunction

    function automatic int ref_latency(input logic [31:0] x);
        int fl = 0;
        int b, n;
        for (int i = 0; i < 32; i++) if (x[i]) fl = i;
        b = fl / 2 + 1;
        n = (b + C_LEVELS - 1) / C_LEVELS;
        if (n < 1) n = 1;
        return n + 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_ctl"}, {29'd0, ld, mux_select, ld_out}, 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    // Called at a negedge; returns at a negedge in IDLE.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] exp_res,
                          input int exp_lat, input logic exp_err, input bit chk_res,
                          input int ack_wait, input bit busy_start);
        int lat = 0, ld_cnt = 0, ldo_cnt = 0, w = 0, bad = 0;
        logic [31:0] res_hold;
        while (!ready && w < 20) begin
            @(posedge clk); @(negedge clk); w++;
        end
        chk({tag, "_ready_wait"}, 32'(ready), 32'd1);
        start = 1'b1; in_num = x;
        @(posedge clk); @(negedge clk);
        start = 1'b0; in_num = $urandom;
        while (!result_valid && lat < 20) begin
            ld_cnt += int'(ld); ldo_cnt += int'(ld_out);
            if (busy_start) begin
                start = 1'($urandom_range(0, 1)); in_num = $urandom;
            end
            @(posedge clk); @(negedge clk); lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_ld_cycles"}, 32'(ld_cnt), 32'(exp_lat - 1));
        chk({tag, "_ldout_cycles"}, 32'(ldo_cnt), 32'd1);
        chk({tag, "_dp_num"}, dp_num, x);
        if (chk_res) chk({tag, "_res"}, res, exp_res);
        res_hold = res;
        for (int i = 0; i < ack_wait; i++) begin
            @(posedge clk); @(negedge clk);
            if (!result_valid || ld || ld_out || res !== res_hold || error !== exp_err) bad++;
        end
        if (ack_wait > 0) chk({tag, "_hold_disturbed"}, 32'(bad), 32'd0);
        start = 1'b0;
        result_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        result_ack = 1'b0;
        chk({tag, "_ack_ready"}, 32'(ready), 32'd1);
        chk({tag, "_ack_valid"}, 32'(result_valid), 32'd0);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat, w;
        logic [31:0] x;

        vecs[0] = '{32'd144,        32'd12,    3};
        vecs[1] = '{32'hFFFF_FFFF,  32'd65535, 5};
        vecs[2] = '{32'd0,          32'd0,     3};
        vecs[3] = '{32'd1,          32'd1,     3};
        vecs[4] = '{32'd2,          32'd1,     3};
        vecs[5] = '{32'd4095,       32'd63,    3};
        vecs[6] = '{32'd4096,       32'd64,    4};
        vecs[7] = '{32'd1000000,    32'd1000,  4};
        vecs[8] = '{32'h00FF_FFFF,  32'd4095,  4};
        vecs[9] = '{32'h0100_0000,  32'd4096,  5};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_dp_num", dp_num, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].res, vecs[i].lat, 1'b0, 1'b1, 0, 1'b0);

        // Back-to-back with ack tied high and start held while busy.
        result_ack = 1'b1;
        start = 1'b1; in_num = 32'd1000000;
        @(posedge clk); @(negedge clk);
        in_num = 32'd2;
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd4);
        chk("b2b_first_res", res, 32'd1000);
        chk("b2b_busy_start_ignored", dp_num, 32'd1000000);
        @(posedge clk); @(negedge clk);
        chk("b2b_ready_after_ack", 32'(ready), 32'd1);
        chk("b2b_no_accept_in_done", dp_num, 32'd1000000);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("b2b_second_accept", dp_num, 32'd2);
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'd3);
        chk("b2b_second_res", res, 32'd1);
        result_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        result_ack = 1'b0;

        // Asynchronous reset mid-ITER.
        start = 1'b1; in_num = 32'd65536;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_in_iter_state", {30'd0, ld, mux_select}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_dp_num", dp_num, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 32'd49, 32'd7, 3, 1'b0, 1'b1, 0, 1'b0);

        // Overrun: datapath never reports finished.
        force_unf = 1'b1;
        run_op("overrun", $urandom, 32'd0, C_MAX_ITER + 2, 1'b1, 1'b0, 3, 1'b0);
        force_unf = 1'b0;
        run_op("post_overrun", 32'd81, 32'd9, 3, 1'b0, 1'b1, 0, 1'b0);

        // Withheld ack.
        run_op("ack_hold", 32'd144, 32'd12, 3, 1'b0, 1'b1, 10, 1'b0);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), x, ref_isqrt(x), ref_latency(x), 1'b0, 1'b1,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        w = 0;
        while (!ready && w < 20) begin
            @(posedge clk); @(negedge clk); w++;
        end
        chk_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
